// File: rtl/bbox_overlay_pkg.sv
// Shared types and helpers for the 4-pixel/clock bounding-box overlay stage.
// Box coordinates are held at BOX_W bits internally; top-level CW inputs are zero-extended.
package bbox_overlay_pkg;

    localparam int PPC    = 4;
    localparam int PIX_W  = 24;
    localparam int BEAT_W = PPC * PIX_W;
    localparam int BOX_W  = 16;

    typedef struct packed {
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
    } rgb_t;

    typedef struct packed {
        logic [BOX_W-1:0] x0;
        logic [BOX_W-1:0] y0;
        logic [BOX_W-1:0] x1;
        logic [BOX_W-1:0] y1;
    } bbox_t;

    function automatic rgb_t lane_pixel(input logic [BEAT_W-1:0] beat, input int k);
        return rgb_t'(beat[PIX_W*k +: PIX_W]);
    endfunction

endpackage

// File: rtl/bbox_hit.sv
// Per-lane hit test: is pixel (x,y) on the box outline (or crosshair when
// BBOX_CROSSHAIR_EN is defined). Purely combinational.
module bbox_hit
    import bbox_overlay_pkg::*;
#(
    parameter int THICK = 1
) (
    input  logic [BOX_W-1:0] i_x,
    input  logic [BOX_W-1:0] i_y,
    input  bbox_t            i_box,
`ifdef BBOX_CROSSHAIR_EN
    input  logic [BOX_W-1:0] i_cx,
    input  logic [BOX_W-1:0] i_cy,
`endif
    output logic             o_hit
);

    localparam int XW = BOX_W + 1;

    // One spare bit so x0+THICK and x+THICK never wrap.
    logic [XW-1:0] w_x, w_y, w_x0, w_y0, w_x1, w_y1, w_t;
    logic          w_in, w_edge;

    assign w_x  = {1'b0, i_x};
    assign w_y  = {1'b0, i_y};
    assign w_x0 = {1'b0, i_box.x0};
    assign w_y0 = {1'b0, i_box.y0};
    assign w_x1 = {1'b0, i_box.x1};
    assign w_y1 = {1'b0, i_box.y1};
    assign w_t  = XW'(THICK);

    // An inverted box (x0>x1 or y0>y1) can never satisfy w_in.
    assign w_in   = (w_x >= w_x0) && (w_x <= w_x1) && (w_y >= w_y0) && (w_y <= w_y1);
    assign w_edge = (w_x < w_x0 + w_t) || (w_x + w_t > w_x1) ||
                    (w_y < w_y0 + w_t) || (w_y + w_t > w_y1);

`ifdef BBOX_CROSSHAIR_EN
    assign o_hit = w_in && (w_edge || (i_x == i_cx) || (i_y == i_cy));
`else
    assign o_hit = w_in && w_edge;
`endif

endmodule

// File: rtl/bbox_overlay_4ppc.sv
// AXI4-Stream 4 pixel/clock bounding-box overlay with frame-synchronous box update.
// Optional crosshair through the box centre under macro BBOX_CROSSHAIR_EN.
module bbox_overlay_4ppc
    import bbox_overlay_pkg::*;
#(
    parameter int          WIDTH  = 64,
    parameter int          HEIGHT = 64,
    parameter int          CW     = 12,
    parameter int          THICK  = 1,
    parameter logic [23:0] COLOR  = 24'hFF0000
) (
    input  logic                s_axis_video_aclk,
    input  logic                rst,
    input  logic [BEAT_W-1:0]   VIDEO_IN_tdata,
    input  logic                VIDEO_IN_tvalid,
    output logic                VIDEO_IN_tready,
    input  logic                VIDEO_IN_tuser,
    input  logic                VIDEO_IN_tlast,
    output logic [BEAT_W-1:0]   VIDEO_OUT_tdata,
    output logic                VIDEO_OUT_tvalid,
    input  logic                VIDEO_OUT_tready,
    output logic                VIDEO_OUT_tuser,
    output logic                VIDEO_OUT_tlast,
    input  logic [CW-1:0]       bbox_x0,
    input  logic [CW-1:0]       bbox_y0,
    input  logic [CW-1:0]       bbox_x1,
    input  logic [CW-1:0]       bbox_y1,
    input  logic                bbox_valid,
    output logic                frame_err
);

    localparam int              COLS     = WIDTH / PPC;
    localparam int              CLW      = $clog2(COLS + 1);
    localparam int              RW       = $clog2(HEIGHT + 2);
    localparam logic [CLW-1:0]  LAST_COL = CLW'(COLS - 1);
    localparam bbox_t           BOX_NONE = '{x0: BOX_W'(1), y0: '0, x1: '0, y1: '0};

    logic [CLW-1:0]             r_col;
    logic [RW-1:0]              r_row;
    logic                       r_first;
    logic                       r_err;
    bbox_t                      r_pend, r_act;
    logic                       r_vld, r_user, r_last;
    logic [PPC-1:0][PIX_W-1:0]  r_data;

    logic                       w_acc, w_sof, w_eol, w_len_err, w_sync_err;
    logic [CLW-1:0]             w_col;
    logic [RW-1:0]              w_row, w_row_inc;
    bbox_t                      w_box, w_new;
    logic [PPC-1:0][PIX_W-1:0]  w_pix;

    assign VIDEO_IN_tready  = !r_vld || VIDEO_OUT_tready;
    assign VIDEO_OUT_tvalid = r_vld;
    assign VIDEO_OUT_tdata  = r_data;
    assign VIDEO_OUT_tuser  = r_user;
    assign VIDEO_OUT_tlast  = r_last;
    assign frame_err        = r_err;

    assign w_acc = VIDEO_IN_tvalid && VIDEO_IN_tready;
    assign w_sof = w_acc && VIDEO_IN_tuser;
    assign w_col = VIDEO_IN_tuser ? '0 : r_col;
    assign w_row = VIDEO_IN_tuser ? '0 : r_row;
    assign w_row_inc = (w_row == {RW{1'b1}}) ? w_row : w_row + RW'(1);

    // A line ends on tlast or on the last column; disagreement between the two is an error.
    assign w_eol      = VIDEO_IN_tlast || (w_col == LAST_COL);
    assign w_len_err  = VIDEO_IN_tlast != (w_col == LAST_COL);
    // After a complete frame the row counter has already stepped past the last line.
    assign w_sync_err = VIDEO_IN_tuser && !r_first && ((r_row != RW'(HEIGHT)) || (r_col != '0));

    assign w_new = '{x0: BOX_W'(bbox_x0), y0: BOX_W'(bbox_y0),
                     x1: BOX_W'(bbox_x1), y1: BOX_W'(bbox_y1)};
    assign w_box = w_sof ? r_pend : r_act;

`ifdef BBOX_CROSSHAIR_EN
    // Centres are taken when the pending box is loaded so the pixel path has no adder.
    logic [BOX_W-1:0] r_pend_cx, r_pend_cy, r_act_cx, r_act_cy, w_cx, w_cy;
    logic [BOX_W:0]   w_sx, w_sy;

    assign w_sx = {1'b0, w_new.x0} + {1'b0, w_new.x1};
    assign w_sy = {1'b0, w_new.y0} + {1'b0, w_new.y1};
    assign w_cx = w_sof ? r_pend_cx : r_act_cx;
    assign w_cy = w_sof ? r_pend_cy : r_act_cy;

    always_ff @(posedge s_axis_video_aclk) begin
        if (rst) begin
            r_pend_cx <= '0;
            r_pend_cy <= '0;
            r_act_cx  <= '0;
            r_act_cy  <= '0;
        end else begin
            if (w_sof) begin
                r_act_cx <= r_pend_cx;
                r_act_cy <= r_pend_cy;
            end
            if (bbox_valid) begin
                r_pend_cx <= w_sx[BOX_W:1];
                r_pend_cy <= w_sy[BOX_W:1];
            end
        end
    end
`endif

    for (genvar k = 0; k < PPC; k++) begin : g_lane
        logic [BOX_W-1:0] w_x;
        logic [PIX_W-1:0] w_in_pix;
        logic             w_hit;

        assign w_x      = BOX_W'({w_col, 2'(k)});
        assign w_in_pix = lane_pixel(VIDEO_IN_tdata, k);

        bbox_hit #(.THICK(THICK)) u_hit (
            .i_x   (w_x),
            .i_y   (BOX_W'(w_row)),
            .i_box (w_box),
`ifdef BBOX_CROSSHAIR_EN
            .i_cx  (w_cx),
            .i_cy  (w_cy),
`endif
            .o_hit (w_hit)
        );

        assign w_pix[k] = w_hit ? COLOR : w_in_pix;
    end

    always_ff @(posedge s_axis_video_aclk) begin
        if (rst) begin
            r_col   <= '0;
            r_row   <= '0;
            r_first <= 1'b1;
            r_err   <= 1'b0;
            r_pend  <= BOX_NONE;
            r_act   <= BOX_NONE;
            r_vld   <= 1'b0;
            r_user  <= 1'b0;
            r_last  <= 1'b0;
            r_data  <= '0;
        end else begin
            if (w_acc) begin
                r_col  <= w_eol ? '0 : w_col + CLW'(1);
                r_row  <= w_eol ? w_row_inc : w_row;
                r_vld  <= 1'b1;
                r_data <= w_pix;
                r_user <= VIDEO_IN_tuser;
                r_last <= VIDEO_IN_tlast;
                if (w_len_err || w_sync_err)
                    r_err <= 1'b1;
                if (VIDEO_IN_tuser) begin
                    r_first <= 1'b0;
                    r_act   <= r_pend;
                end
            end else if (VIDEO_OUT_tready) begin
                r_vld <= 1'b0;
            end
            if (bbox_valid)
                r_pend <= w_new;
        end
    end

endmodule

// File: tb/tb_bbox_overlay_4ppc.sv
// Self-checking bench for bbox_overlay_4ppc: reference model scoreboard plus
// table-driven pixel checks on captured output frames.
module tb_bbox_overlay_4ppc;
    import bbox_overlay_pkg::*;

    localparam int          W = 64, H = 64, CW = 12, TH = 1;
    localparam logic [23:0] RED = 24'hFF0000, GREY = 24'h808080;

    logic          clk = 1'b0;
    logic          rst;
    logic [95:0]   VIDEO_IN_tdata;
    logic          VIDEO_IN_tvalid, VIDEO_IN_tready, VIDEO_IN_tuser, VIDEO_IN_tlast;
    logic [95:0]   VIDEO_OUT_tdata;
    logic          VIDEO_OUT_tvalid, VIDEO_OUT_tready, VIDEO_OUT_tuser, VIDEO_OUT_tlast;
    logic [CW-1:0] bbox_x0, bbox_y0, bbox_x1, bbox_y1;
    logic          bbox_valid, frame_err;

    bbox_overlay_4ppc #(.WIDTH(W), .HEIGHT(H), .CW(CW), .THICK(TH), .COLOR(RED)) dut (
        .s_axis_video_aclk (clk),
        .rst               (rst),
        .VIDEO_IN_tdata    (VIDEO_IN_tdata),
        .VIDEO_IN_tvalid   (VIDEO_IN_tvalid),
        .VIDEO_IN_tready   (VIDEO_IN_tready),
        .VIDEO_IN_tuser    (VIDEO_IN_tuser),
        .VIDEO_IN_tlast    (VIDEO_IN_tlast),
        .VIDEO_OUT_tdata   (VIDEO_OUT_tdata),
        .VIDEO_OUT_tvalid  (VIDEO_OUT_tvalid),
        .VIDEO_OUT_tready  (VIDEO_OUT_tready),
        .VIDEO_OUT_tuser   (VIDEO_OUT_tuser),
        .VIDEO_OUT_tlast   (VIDEO_OUT_tlast),
        .bbox_x0           (bbox_x0),
        .bbox_y0           (bbox_y0),
        .bbox_x1           (bbox_x1),
        .bbox_y1           (bbox_y1),
        .bbox_valid        (bbox_valid),
        .frame_err         (frame_err)
    );

    always #5 clk = ~clk;

    int errs = 0, checks = 0;
    logic [97:0] exp_q[$];
    int px0 = 1, py0 = 0, px1 = 0, py1 = 0;   // pending box as the model sees it
    int ax0 = 1, ay0 = 0, ax1 = 0, ay1 = 0;   // box in force for the current frame
    bit mon_en = 0;
    int bp_mode = 0;                          // 0: always ready, 1: random, 2: never ready
    logic [23:0] cap [0:H-1][0:W-1];
    logic [23:0] ref_cap [0:H-1][0:W-1];

    typedef struct { int fr; int x; int y; logic [23:0] px; } vec_t;
    vec_t tbl[$];

    task automatic chk(input string nm, input logic [99:0] got, input logic [99:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got %h expected %h", nm, got, exp);
        end
    endtask

    // Outline = inside the box and closer than TH to some edge.
    function automatic bit ref_red(input int x, y, x0, y0, x1, y1);
        int d;
        if (x < x0 || x > x1 || y < y0 || y > y1) return 0;
        d = x - x0;
        if (x1 - x < d) d = x1 - x;
        if (y - y0 < d) d = y - y0;
        if (y1 - y < d) d = y1 - y;
        if (d < TH) return 1;
`ifdef BBOX_CROSSHAIR_EN
        if (x == (x0 + x1) / 2 || y == (y0 + y1) / 2) return 1;
`endif
        return 0;
    endfunction

    task automatic model_accept(input logic [95:0] d, input bit u, l, input int y, c);
        logic [95:0] e;
        if (u) begin
            ax0 = px0; ay0 = py0; ax1 = px1; ay1 = py1;
        end
        for (int k = 0; k < 4; k++)
            e[24*k +: 24] = ref_red(4*c + k, y, ax0, ay0, ax1, ay1) ? RED : d[24*k +: 24];
        exp_q.push_back({u, l, e});
    endtask

    initial forever begin
        @(posedge clk); #1;
        case (bp_mode)
            0:       VIDEO_OUT_tready = 1'b1;
            1:       VIDEO_OUT_tready = ($urandom_range(0, 1) == 1);
            default: VIDEO_OUT_tready = 1'b0;
        endcase
    end

    // Output monitor: scoreboard, stall stability, frame capture.
    initial begin
        logic        prev_stall;
        logic [97:0] prev_beat;
        logic [97:0] e;
        int orow, ocol;
        prev_stall = 0; prev_beat = '0; orow = 0; ocol = 0;
        forever begin
            @(negedge clk);
            if (!mon_en) begin
                prev_stall = 0;
            end else begin
                if (prev_stall)
                    chk("stall_hold", {1'b0, VIDEO_OUT_tvalid, VIDEO_OUT_tuser, VIDEO_OUT_tlast, VIDEO_OUT_tdata},
                        {2'b01, prev_beat});
                prev_stall = VIDEO_OUT_tvalid && !VIDEO_OUT_tready;
                prev_beat  = {VIDEO_OUT_tuser, VIDEO_OUT_tlast, VIDEO_OUT_tdata};
                if (VIDEO_OUT_tvalid && VIDEO_OUT_tready) begin
                    if (exp_q.size() == 0) begin
                        chk("unexpected_beat", {2'b0, prev_beat}, 100'h0);
                    end else begin
                        e = exp_q.pop_front();
                        chk("out_beat", {2'b0, prev_beat}, {2'b0, e});
                    end
                    if (VIDEO_OUT_tuser) begin orow = 0; ocol = 0; end
                    for (int k = 0; k < 4; k++)
                        if (orow < H && 4*ocol + k < W) cap[orow][4*ocol + k] = VIDEO_OUT_tdata[24*k +: 24];
                    if (VIDEO_OUT_tlast) begin orow++; ocol = 0; end
                    else ocol++;
                end
            end
        end
    end

    task automatic send(input logic [95:0] d, input bit u, l, input int y, c,
                        input bit pb, input int b0, b1, b2, b3);
        int n = 0;
        VIDEO_IN_tdata = d; VIDEO_IN_tuser = u; VIDEO_IN_tlast = l; VIDEO_IN_tvalid = 1'b1;
        if (pb) begin
            bbox_x0 = CW'(b0); bbox_y0 = CW'(b1); bbox_x1 = CW'(b2); bbox_y1 = CW'(b3); bbox_valid = 1'b1;
        end
        @(negedge clk);
        while (!VIDEO_IN_tready && n < 1000) begin @(negedge clk); n++; end
        if (n >= 1000) chk("in_ready_timeout", 100'(n), 100'h0);
        model_accept(d, u, l, y, c);
        if (pb) begin px0 = b0; py0 = b1; px1 = b2; py1 = b3; end
        @(posedge clk); #1;
        VIDEO_IN_tvalid = 1'b0; bbox_valid = 1'b0;
    endtask

    task automatic set_box(input int b0, b1, b2, b3);
        bbox_x0 = CW'(b0); bbox_y0 = CW'(b1); bbox_x1 = CW'(b2); bbox_y1 = CW'(b3); bbox_valid = 1'b1;
        @(posedge clk); #1;
        bbox_valid = 1'b0;
        px0 = b0; py0 = b1; px1 = b2; py1 = b3;
    endtask

    task automatic drain();
        int n = 0;
        while (exp_q.size() != 0 && n < 5000) begin @(negedge clk); n++; end
        chk("drain_left", 100'(exp_q.size()), 100'h0);
        @(posedge clk); #1;
    endtask

    task automatic frame(input int id, input bit rnd, input bit cnt_chk, input int short_len,
                         input int mid_row, input int m0, m1, m2, m3,
                         input bit co, input int c0, c1, c2, c3);
        logic [95:0] d;
        int n, got, want;
        for (int y = 0; y < H; y++) begin
            if (y == mid_row) set_box(m0, m1, m2, m3);
            n = (y == 0) ? short_len : W / 4;
            for (int c = 0; c < n; c++) begin
                d = rnd ? {$urandom, $urandom, $urandom} : {4{GREY}};
                send(d, (y == 0 && c == 0), (c == n - 1), y, c, co && y == 0 && c == 0, c0, c1, c2, c3);
            end
        end
        drain();
        foreach (tbl[i])
            if (tbl[i].fr == id)
                chk($sformatf("f%0d_pix_%0d_%0d", id, tbl[i].x, tbl[i].y),
                    100'(cap[tbl[i].y][tbl[i].x]), 100'(tbl[i].px));
        if (cnt_chk) begin
            got = 0; want = 0;
            for (int y = 0; y < H; y++)
                for (int x = 0; x < W; x++) begin
                    if (cap[y][x] == RED) got++;
                    if (ref_red(x, y, ax0, ay0, ax1, ay1)) want++;
                end
            chk($sformatf("f%0d_red_count", id), 100'(got), 100'(want));
        end
    endtask

    task automatic add(input int fr, x, y, input logic [23:0] px);
        vec_t v;
        v.fr = fr; v.x = x; v.y = y; v.px = px;
        tbl.push_back(v);
    endtask

    initial begin
        int mism;
        int r0, r1, r2, r3;
        logic [23:0] xh;
`ifdef BBOX_CROSSHAIR_EN
        xh = RED;
`else
        xh = GREY;
`endif
        add(0, 0, 0, GREY);  add(0, 3, 3, GREY);
        add(1, 0, 0, RED);   add(1, 3, 0, RED);   add(1, 0, 3, RED);   add(1, 3, 3, RED);
        add(1, 1, 1, GREY);  add(1, 2, 2, GREY);  add(1, 4, 0, GREY);
        add(2, 8, 8, RED);   add(2, 15, 8, RED);  add(2, 8, 12, RED);  add(2, 9, 9, GREY);
        add(2, 9, 8, RED);   add(2, 10, 8, RED);  add(2, 11, 8, RED);  add(2, 15, 15, RED);
        add(2, 16, 8, GREY); add(2, 7, 8, GREY);  add(2, 8, 16, GREY); add(2, 12, 14, GREY);
        add(4, 60, 60, RED); add(4, 63, 60, RED); add(4, 60, 63, RED); add(4, 62, 60, RED);
        add(4, 61, 61, GREY); add(4, 63, 63, GREY); add(4, 0, 60, GREY); add(4, 59, 60, GREY);
        add(6, 10, 10, GREY); add(6, 20, 5, GREY); add(6, 15, 5, GREY);
        add(7, 10, 15, RED); add(7, 20, 12, RED); add(7, 12, 12, GREY);
        add(7, 15, 12, xh);  add(7, 12, 15, xh);  add(7, 15, 15, xh);
        add(9, 8, 8, RED);   add(9, 9, 9, GREY);

        rst = 1'b1; VIDEO_IN_tvalid = 1'b0; VIDEO_IN_tdata = '0; VIDEO_IN_tuser = 1'b0;
        VIDEO_IN_tlast = 1'b0; bbox_valid = 1'b0; VIDEO_OUT_tready = 1'b1;
        bbox_x0 = '0; bbox_y0 = '0; bbox_x1 = '0; bbox_y1 = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_state", {2'b0, VIDEO_OUT_tvalid, VIDEO_OUT_tuser, VIDEO_OUT_tlast, frame_err, VIDEO_OUT_tdata},
            {4'b0, 96'h0});
        chk("reset_in_ready", 100'(VIDEO_IN_tready), 100'h1);
        @(posedge clk); #1;
        rst = 1'b0; mon_en = 1;

        // Box pulsed mid-frame applies only from the next frame; pulse on tuser waits a frame.
        frame(0, 0, 1, 16, 2, 0, 0, 3, 3, 0, 0, 0, 0, 0);
        frame(1, 0, 1, 16, -1, 0, 0, 0, 0, 1, 8, 8, 15, 15);
        frame(2, 0, 1, 16, -1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        ref_cap = cap;
        bp_mode = 1;
        frame(3, 0, 1, 16, -1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        mism = 0;
        for (int y = 0; y < H; y++)
            for (int x = 0; x < W; x++)
                if (cap[y][x] !== ref_cap[y][x]) mism++;
        chk("bp_frame_identical", 100'(mism), 100'h0);

        set_box(60, 60, 80, 80);
        frame(4, 0, 1, 16, -1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        r0 = $urandom_range(0, 70); r1 = $urandom_range(0, 70);
        r2 = $urandom_range(0, 70); r3 = $urandom_range(0, 70);
        set_box(r0, r1, r2, r3);
        frame(5, 1, 0, 16, -1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        set_box(20, 5, 10, 30);
        frame(6, 0, 1, 16, -1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        set_box(10, 10, 20, 20);
        frame(7, 0, 1, 16, -1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        chk("err_clean_frames", 100'(frame_err), 100'h0);

        // Short first line: sticky error, then resync on the next frame.
        set_box(8, 8, 15, 15);
        frame(8, 0, 0, 8, -1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        chk("err_short_line", 100'(frame_err), 100'h1);
        frame(9, 0, 1, 16, -1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        chk("err_sticky", 100'(frame_err), 100'h1);

        // Reset with an output beat held by backpressure.
        bp_mode = 2; mon_en = 0;
        @(posedge clk); #1;
        VIDEO_IN_tdata = {4{GREY}}; VIDEO_IN_tuser = 1'b1; VIDEO_IN_tlast = 1'b0; VIDEO_IN_tvalid = 1'b1;
        @(posedge clk); #1;
        VIDEO_IN_tvalid = 1'b0;
        @(negedge clk);
        chk("held_beat_valid", 100'(VIDEO_OUT_tvalid), 100'h1);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("rst_mid_frame", {VIDEO_OUT_tvalid, frame_err, 2'b0, VIDEO_OUT_tdata}, 100'h0);
        exp_q.delete();

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
